// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the multiplier request arbiter.
package fpu_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int TAG_W_DEF   = $clog2(NUM_REQ_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // IEEE exception flags, bit-compatible with fpnew_pkg::status_t
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  // Round-robin successor of a requester index
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fpu_mul_arbiter_rr_select.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic                 valid_o
);

  // Walk N positions starting at the pointer; first hit wins
  always_comb begin
    int idx;
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (j == idx && !valid_o && req_i[j]) begin
          grant_o[j] = 1'b1;
          valid_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one fpnew_top multiplier among NUM_REQ requesters with round-robin
// issue, an outstanding-operation credit counter and tag-routed responses.
module fpu_mul_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0][1:0][WIDTH-1:0]   req_operands_i,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  input  logic [NUM_REQ-1:0]                   rsp_ready_i,
  output logic [WIDTH-1:0]                     rsp_result_o,
  output logic [4:0]                           rsp_status_o,
  output logic                                 fpu_in_valid_o,
  input  logic                                 fpu_in_ready_i,
  output logic [1:0][WIDTH-1:0]                fpu_operands_o,
  output logic [$clog2(NUM_REQ)-1:0]           fpu_tag_o,
  input  logic                                 fpu_out_valid_i,
  input  logic [WIDTH-1:0]                     fpu_result_i,
  input  logic [4:0]                           fpu_status_i,
  input  logic [$clog2(NUM_REQ)-1:0]           fpu_tag_i,
  output logic                                 fpu_out_ready_o,
  output logic                                 busy_o
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  arb_state_e       state_q;
  logic [TAG_W-1:0] rr_ptr_q;
  logic [TAG_W-1:0] grant_q;
  logic [CNT_W-1:0] cnt_q;

  logic [NUM_REQ-1:0] sel_oh;
  logic               sel_any;
  logic [TAG_W-1:0]   sel_idx;
  logic [TAG_W-1:0]   cur_idx;
  logic               cur_valid;
  logic               credit;
  logic               issue_hs;
  logic               rsp_hs;

  rr_select #(.N(NUM_REQ)) u_rr_select (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (sel_oh),
    .valid_o (sel_any)
  );

  // One-hot pick to binary index
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel_oh[i]) sel_idx = TAG_W'(i);
  end

  // Response routing by returned tag; gated off while reset is held
  always_comb begin
    rsp_valid_o     = '0;
    fpu_out_ready_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fpu_tag_i == TAG_W'(i)) begin
        rsp_valid_o[i]  = fpu_out_valid_i & rst_ni;
        fpu_out_ready_o = rsp_ready_i[i] & rst_ni;
      end
    end
  end

  assign rsp_result_o = rst_ni ? fpu_result_i : '0;
  assign rsp_status_o = rst_ni ? fpu_status_i : '0;
  assign rsp_hs       = fpu_out_valid_i & fpu_out_ready_o;

  // A response retiring this cycle frees its credit for a same-cycle issue
  assign credit = (cnt_q < CNT_W'(MAX_OUT)) | rsp_hs;

  // Current grant: the held one when locked, else a fresh round-robin pick
  always_comb begin
    cur_idx   = sel_idx;
    cur_valid = sel_any & credit;
    if (state_q == LOCKED) begin
      cur_idx   = grant_q;
      cur_valid = 1'b1;
    end
    cur_valid = cur_valid & rst_ni;
  end

  assign issue_hs       = cur_valid & fpu_in_ready_i;
  assign fpu_in_valid_o = cur_valid;
  assign fpu_tag_o      = cur_valid ? cur_idx : '0;
  assign fpu_operands_o = cur_valid ? req_operands_i[cur_idx] : '0;

  // Accept pulse back to the requester that completed the issue handshake
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (issue_hs && cur_idx == TAG_W'(i)) req_ready_o[i] = 1'b1;
  end

  assign busy_o = (cnt_q != '0) | (state_q == LOCKED);

  // Grant FSM: hold a presented grant until the multiplier accepts it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cur_valid && !fpu_in_ready_i) begin
            state_q <= LOCKED;
            grant_q <= cur_idx;
          end
        end
        LOCKED: begin
          if (fpu_in_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (issue_hs) rr_ptr_q <= TAG_W'(wrap_inc(int'(cur_idx), NUM_REQ));
    end
  end

  // Outstanding-operation counter; a stray response at zero is absorbed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({issue_hs, rsp_hs})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter; the bench plays the fpnew_top side.
module tb_fpu_mul_arbiter;

  logic                  clk;
  logic                  rst_n;
  logic [3:0]            req_valid;
  logic [3:0]            req_ready;
  logic [3:0][1:0][31:0] req_ops;
  logic [3:0]            rsp_valid;
  logic [3:0]            rsp_ready;
  logic [31:0]           rsp_result;
  logic [4:0]            rsp_status;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0][31:0]      fpu_ops;
  logic [1:0]            fpu_tag;
  logic                  out_valid;
  logic [31:0]           fpu_result;
  logic [4:0]            fpu_status;
  logic [1:0]            out_tag;
  logic                  out_ready;
  logic                  busy;

  int ncmp = 0;
  int nfail = 0;

  fpu_mul_arbiter #(.NUM_REQ(4), .WIDTH(32), .MAX_OUT(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_operands_i (req_ops),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_result_o   (rsp_result),
    .rsp_status_o   (rsp_status),
    .fpu_in_valid_o (in_valid),
    .fpu_in_ready_i (in_ready),
    .fpu_operands_o (fpu_ops),
    .fpu_tag_o      (fpu_tag),
    .fpu_out_valid_i(out_valid),
    .fpu_result_i   (fpu_result),
    .fpu_status_i   (fpu_status),
    .fpu_tag_i      (out_tag),
    .fpu_out_ready_o(out_ready),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_ops    = '0;
    rsp_ready  = '0;
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    fpu_result = '0;
    fpu_status = '0;
    out_tag    = '0;
    for (int r = 0; r < 4; r++) begin
      req_ops[r][0] = 32'hA000_0000 | r;
      req_ops[r][1] = 32'hB000_0000 | r;
    end

    // Reset state: requests present but nothing granted
    #3;
    chk("rst_in_valid", 64'(in_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    cyc();
    rst_n     = 1'b1;
    req_valid = 4'h0;
    cyc();

    // 1.5 x 2.0 from requester 0
    req_ops[0][0] = 32'h3FC0_0000;
    req_ops[0][1] = 32'h4000_0000;
    req_valid     = 4'b0001;
    #1;
    chk("mul_in_valid", 64'(in_valid), 64'd1);
    chk("mul_tag", 64'(fpu_tag), 64'd0);
    chk("mul_operands", 64'(fpu_ops), 64'h4000_0000_3FC0_0000);
    chk("mul_req_ready", 64'(req_ready), 64'b0001);
    cyc();
    req_valid = 4'h0;
    #1;
    chk("mul_idle_valid", 64'(in_valid), 64'd0);
    chk("mul_busy", 64'(busy), 64'd1);
    out_valid  = 1'b1;
    out_tag    = 2'd0;
    fpu_result = 32'h4040_0000;
    fpu_status = 5'd0;
    rsp_ready  = 4'b0001;
    #1;
    chk("mul_rsp_valid", 64'(rsp_valid), 64'b0001);
    chk("mul_rsp_result", 64'(rsp_result), 64'h4040_0000);
    chk("mul_rsp_status", 64'(rsp_status), 64'd0);
    chk("mul_out_ready", 64'(out_ready), 64'd1);
    cyc();
    out_valid = 1'b0;
    #1;
    chk("mul_busy_done", 64'(busy), 64'd0);

    // Stray response with nothing outstanding must not wrap the count
    out_valid = 1'b1;
    out_tag   = 2'd1;
    rsp_ready = 4'hF;
    #1;
    chk("stray_rsp_valid", 64'(rsp_valid), 64'b0010);
    cyc();
    out_valid = 1'b0;
    #1;
    chk("stray_busy", 64'(busy), 64'd0);

    // All four requesting: 0,1,2,3,0 back to back
    rst_pulse();
    req_valid = 4'hF;
    in_ready  = 1'b1;
    #1;
    chk("rr_tag0", 64'(fpu_tag), 64'd0);
    chk("rr_ready0", 64'(req_ready), 64'b0001);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      out_valid = 1'b1;
      out_tag   = 2'd0;
      rsp_ready = 4'hF;
      #1;
      chk($sformatf("rr_tag%0d", k), 64'(fpu_tag), 64'(k % 4));
      chk($sformatf("rr_valid%0d", k), 64'(in_valid), 64'd1);
    end
    cyc();
    req_valid = 4'h0;
    cyc();
    out_valid = 1'b0;

    // Stall with requester 2 granted; requester 1 arriving must wait
    rst_pulse();
    rsp_ready = 4'h0;
    req_valid = 4'b0100;
    in_ready  = 1'b0;
    #1;
    chk("lock_valid", 64'(in_valid), 64'd1);
    chk("lock_tag", 64'(fpu_tag), 64'd2);
    chk("lock_ready0", 64'(req_ready), 64'd0);
    cyc();
    req_valid = 4'b0110;
    #1;
    chk("lock_tag_held", 64'(fpu_tag), 64'd2);
    chk("lock_ops_held", 64'(fpu_ops), {32'hB000_0002, 32'hA000_0002});
    chk("lock_ready1", 64'(req_ready), 64'd0);
    chk("lock_busy", 64'(busy), 64'd1);
    cyc();
    chk("lock_tag_held2", 64'(fpu_tag), 64'd2);
    chk("lock_valid2", 64'(in_valid), 64'd1);
    cyc();
    in_ready = 1'b1;
    #1;
    chk("lock_hs_ready", 64'(req_ready), 64'b0100);
    chk("lock_hs_tag", 64'(fpu_tag), 64'd2);
    cyc();
    req_valid = 4'b0010;
    #1;
    chk("lock_next_tag", 64'(fpu_tag), 64'd1);
    chk("lock_next_ready", 64'(req_ready), 64'b0010);

    // Credit exhaustion: results held back, fifth issue waits for one to retire
    cyc();
    rst_pulse();
    req_valid = 4'b0001;
    in_ready  = 1'b1;
    out_valid = 1'b1;
    out_tag   = 2'd0;
    rsp_ready = 4'h0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cred_issue%0d", k), 64'(in_valid), 64'd1);
      cyc();
    end
    #1;
    chk("cred_blocked", 64'(in_valid), 64'd0);
    chk("cred_busy", 64'(busy), 64'd1);
    chk("cred_out_ready", 64'(out_ready), 64'd0);
    cyc();
    rsp_ready = 4'b0001;
    #1;
    chk("cred_release_ready", 64'(out_ready), 64'd1);
    chk("cred_fifth_valid", 64'(in_valid), 64'd1);
    chk("cred_fifth_req_ready", 64'(req_ready), 64'b0001);
    cyc();
    rsp_ready = 4'h0;
    #1;
    chk("cred_full_again", 64'(in_valid), 64'd0);
    chk("cred_busy_again", 64'(busy), 64'd1);

    // Reset while locked with three outstanding
    cyc();
    rst_pulse();
    out_valid = 1'b0;
    req_valid = 4'b0001;
    in_ready  = 1'b1;
    cyc();
    cyc();
    cyc();
    req_valid = 4'b1000;
    in_ready  = 1'b0;
    #1;
    chk("rl_tag", 64'(fpu_tag), 64'd3);
    cyc();
    chk("rl_busy", 64'(busy), 64'd1);
    chk("rl_locked_valid", 64'(in_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rl_async_valid", 64'(in_valid), 64'd0);
    chk("rl_async_ready", 64'(req_ready), 64'd0);
    chk("rl_async_busy", 64'(busy), 64'd0);
    chk("rl_async_tag", 64'(fpu_tag), 64'd0);
    chk("rl_async_ops", 64'(fpu_ops), 64'd0);
    rst_n     = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("rl_ptr_zero", 64'(fpu_tag), 64'd0);
    chk("rl_count_zero", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/fpu_mul_arbiter.md
FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4; number of requesters sharing one fpnew_top multiplier (2..8).
REQ-002 SHALL have parameter WIDTH, default 32; operand/result width, matches Features.Width of RV32F.
REQ-003 SHALL have parameter MAX_OUT, default 4; maximum issued-but-unreturned operations (1..15).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  per-requester operation valid.
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept.
REQ-008 SHALL have port req_operands_i  input  NUM_REQ x 2 x WIDTH  per-requester operand pair.
REQ-009 SHALL have port rsp_valid_o  output  NUM_REQ  per-requester result valid.
REQ-010 SHALL have port rsp_ready_i  input  NUM_REQ  per-requester result accept.
REQ-011 SHALL have port rsp_result_o  output  WIDTH  result, shared by all requesters.
REQ-012 SHALL have port rsp_status_o  output  5  IEEE flags (status_t), shared by all requesters.
REQ-013 SHALL have port fpu_in_valid_o  output  1  drives in_valid_i of fpnew_top.
REQ-014 SHALL have port fpu_in_ready_i  input  1  from in_ready_o of fpnew_top.
REQ-015 SHALL have port fpu_operands_o  output  2 x WIDTH  drives operands_i.
REQ-016 SHALL have port fpu_tag_o  output  TAG_W  drives tag_i; TAG_W = clog2(NUM_REQ).
REQ-017 SHALL have ports fpu_out_valid_i / fpu_result_i / fpu_status_i / fpu_tag_i  input  1 / WIDTH / 5 / TAG_W  from out_valid_o / result_o / status_o / tag_o.
REQ-018 SHALL have port fpu_out_ready_o  output  1  drives out_ready_i.
REQ-019 SHALL have port busy_o  output  1  high while outstanding count is non-zero or LOCKED.

Function
REQ-020 States: IDLE (no grant held), LOCKED (grant held, fpu_in_valid_o high, awaiting fpu_in_ready_i).
REQ-021 IDLE: if credit available (count < MAX_OUT) and any req_valid_i high, grant first index at or after rr_ptr (wrapping NUM_REQ-1 -> 0); fpu_in_valid_o asserted same cycle.
REQ-022 Grant handshake (fpu_in_valid_o & fpu_in_ready_i): req_ready_o[grant]=1 that cycle, count+1, rr_ptr <= grant+1 mod NUM_REQ, next state IDLE.
REQ-023 Grant presented without fpu_in_ready_i: next state LOCKED, grant index registered; operands, tag, valid stay stable; no regrant until handshake.
REQ-024 Requester SHALL keep req_valid_i and operands stable while waiting; arbiter does not check.
REQ-025 fpu_tag_o = granted index; fpu_operands_o = req_operands_i[grant]; all zero when no grant.
REQ-026 Response path combinational: rsp_valid_o[fpu_tag_i] = fpu_out_valid_i, other bits 0; fpu_out_ready_o = rsp_ready_i[fpu_tag_i]; rsp_result_o/rsp_status_o pass through.
REQ-027 Response handshake decrements count; issue and response handshakes in same cycle leave count unchanged.
REQ-028 count == MAX_OUT: fpu_in_valid_o held low in IDLE; issue resumes the cycle after a response handshake frees credit (same cycle if simultaneous response).
REQ-029 Response handshake with count == 0 is a protocol error: count saturates at 0 (no underflow).
REQ-030 Single active requester: granted on consecutive cycles, throughput 1/cycle when fpu_in_ready_i high.

Reset
REQ-031 rst_ni low: state IDLE, rr_ptr 0, count 0, grant index 0; req_ready_o 0, fpu_in_valid_o 0, busy_o 0, immediately, independent of clk_i.
REQ-032 Reset mid-operation discards outstanding count; results from fpnew_top must not appear afterwards (flush_i pulsed by owner).

Structure
REQ-033 Package fpu_arb_pkg: NUM_REQ default, TAG_W, arb_state_e {IDLE, LOCKED}; status_t reused from fpnew_pkg.
REQ-034 One sub-module rr_select: combinational round-robin priority pick (req vector, pointer -> one-hot grant, valid).

Verification
REQ-035 Req0 {0x3FC00000, 0x40000000} (1.5x2.0) -> issue tag 0, rsp_valid_o[0] with result 0x40400000, status 0.
REQ-036 All 4 req_valid_i high, fpu_in_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-037 fpu_in_ready_i low 3 cycles with req2 granted -> LOCKED, outputs stable, req1 arrival ignored until handshake.
REQ-038 fpu_out_ready_o tied low, 5 issues -> fpu_in_valid_o low after 4th, busy_o high; release -> 5th issues next cycle.
REQ-039 rst_ni low while LOCKED with count 3 -> all outputs 0 asynchronously, count 0, rr_ptr 0 after release.
